// File: rtl/bit_packer_pkg.sv
// Shared state encoding and sizing helper for the bit packer.
package bit_packer_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int cnt_width(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

endpackage

// File: rtl/bit_packer_if.sv
// Field-in / word-out ready-valid bundle; master drives fields and sinks words.
interface bit_packer_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bit_packer_acc.sv
// MSB-aligned shift accumulator: valid bits occupy the top count_o positions, bits below are zero.
module bit_packer_acc #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int ACC_W = IN_W + OUT_W - 1,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] top_o,
  output logic [CNT_W-1:0] count_o
);

  logic [ACC_W-1:0] acc_q, acc_d, kept;
  logic [CNT_W-1:0] count_q, count_d, rem;

  always_comb begin
    kept    = acc_q;
    rem     = count_q;
    if (pop_i) begin
      kept = acc_q << OUT_W;
      rem  = count_q - CNT_W'(OUT_W);
    end
    acc_d   = kept;
    count_d = rem;
    // New field lands directly below whatever survives the pop.
    if (push_i) begin
      acc_d   = kept | ((ACC_W'(data_i) << (ACC_W - IN_W)) >> rem);
      count_d = rem + CNT_W'(IN_W);
    end
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign top_o   = acc_q[ACC_W-1 -: OUT_W];
  assign count_o = count_q;

endmodule

// File: rtl/bit_packer.sv
// Packs IN_W-bit fields MSB-first into OUT_W-bit words, padding the packet tail with PAD_BIT.
// Optional BIT_PACKER_STATS_EN adds a saturating 16-bit popped-word counter (word_cnt).
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int   IN_W    = 5,
  parameter int   OUT_W   = 8,
  parameter logic PAD_BIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  bit_packer_if.slave  bus
`ifdef BIT_PACKER_STATS_EN
  ,
  output logic [15:0]  word_cnt
`endif
);

  localparam int ACC_W = IN_W + OUT_W - 1;
  localparam int CNT_W = cnt_width(ACC_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] top, pad_mask;
  logic             in_ready, out_valid, out_last;
  logic             push, pop, clear;

  // Handshake outputs decode only registered state, so there is no out_ready -> in_ready path.
  assign in_ready = !reset && (state_q == ST_FILL) && (count <= CNT_W'(ACC_W - IN_W));

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    pad_mask  = '0;
    if (!reset) begin
      if (state_q == ST_FILL) begin
        out_valid = (count >= CNT_W'(OUT_W));
      end else begin
        out_valid = (count != '0);
        out_last  = (count <= CNT_W'(OUT_W));
        if (count < CNT_W'(OUT_W)) pad_mask = {OUT_W{1'b1}} >> count;
      end
    end
  end

  assign push  = bus.in_valid && in_ready;
  assign pop   = out_valid && bus.out_ready;
  assign clear = pop && out_last;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_FILL && push && bus.in_last) state_d = ST_FLUSH;
    else if (state_q == ST_FLUSH && clear)         state_d = ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  bit_packer_acc #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_acc (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (push),
    .pop_i  (pop),
    .clear_i(clear),
    .data_i (bus.in_data),
    .top_o  (top),
    .count_o(count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = reset ? '0 :
                         ((top & ~pad_mask) | (PAD_BIT ? pad_mask : {OUT_W{1'b0}}));

`ifdef BIT_PACKER_STATS_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                             word_cnt_q <= '0;
    else if (pop && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
